// File: rtl/pipelined_shifter_if.sv
// Handshake bundle between the operand source, pipelined_shifter and the result consumer.
// Latency: none (wires only).
// Backpressure: out_ready from the consumer, in_ready back to the source; sticky exists only with SHIFTER_STICKY_EN.
interface pipelined_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d;
    logic [31:0]      s;
    logic [1:0]       op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [TAG_W-1:0] out_tag;
`ifdef SHIFTER_STICKY_EN
    logic             sticky;
`endif

    modport master (
        output in_valid, d, s, op, in_tag, out_ready,
        input  in_ready, out_valid, y, out_tag
`ifdef SHIFTER_STICKY_EN
        , input sticky
`endif
    );

    modport slave (
        input  in_valid, d, s, op, in_tag, out_ready,
        output in_ready, out_valid, y, out_tag
`ifdef SHIFTER_STICKY_EN
        , output sticky
`endif
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined SLL/SRL/SRA/ROR shifter; optional sticky output of discarded bits under SHIFTER_STICKY_EN.
// Latency: ceil(log2(WIDTH)/REG_EVERY) enabled cycles, one operation per cycle.
// Backpressure: whole pipe stalls together when the output is valid and not taken; bubbles are kept.
module pipelined_shifter #(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input logic              clk,
    input logic              rst,
    pipelined_shifter_if.slave bus
);
    localparam int LOG2W = $clog2(WIDTH);
    localparam int L     = (LOG2W + REG_EVERY - 1) / REG_EVERY;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // Everything an operation needs on its way down the levels.
    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] dat;
        logic [LOG2W-1:0] amt;
        logic [1:0]       op;
        logic             sgn;
        logic [TAG_W-1:0] tag;
`ifdef SHIFTER_STICKY_EN
        logic             stk;
`endif
    } stage_t;

    logic   en;
    stage_t entry;
    stage_t lvl_res [LOG2W];
    stage_t stg_q   [L];

    assign en           = ~stg_q[L-1].vld | bus.out_ready;
    assign bus.in_ready = en;
    assign bus.out_valid = stg_q[L-1].vld;
    assign bus.y         = stg_q[L-1].dat;
    assign bus.out_tag   = stg_q[L-1].tag;
`ifdef SHIFTER_STICKY_EN
    assign bus.sticky    = stg_q[L-1].stk;
`endif

    // Capture the operation; an over-range SLL/SRL/SRA is settled here to its fill value with no further shifting.
    always_comb begin
        entry     = '0;
        entry.vld = bus.in_valid;
        entry.dat = bus.d;
        entry.amt = bus.s[LOG2W-1:0];
        entry.op  = bus.op;
        entry.sgn = bus.d[WIDTH-1];
        entry.tag = bus.in_tag;
        if ((|bus.s[31:LOG2W]) && (bus.op != OP_ROR)) begin
            entry.dat = (bus.op == OP_SRA && bus.d[WIDTH-1]) ? '1 : '0;
            entry.amt = '0;
`ifdef SHIFTER_STICKY_EN
            entry.stk = |bus.d;
`endif
        end
    end

    // Mux levels: level k shifts by 2**k; a stage register feeds every REG_EVERY-th level.
    always_comb begin
        stage_t           cur;
        int               sh;
        int               si;
        int               pi;
        logic [WIDTH-1:0] ones;
        ones = '1;
        for (int k = 0; k < LOG2W; k++) begin
            sh = 1 << k;
            si = (k > 0) ? (k / REG_EVERY) - 1 : 0;
            pi = (k > 0) ? k - 1 : 0;
            if (k == 0)
                cur = entry;
            else if (k % REG_EVERY == 0)
                cur = stg_q[si];
            else
                cur = lvl_res[pi];
            lvl_res[k] = cur;
            if (cur.amt[k]) begin
                case (cur.op)
                    OP_SLL: begin
                        lvl_res[k].dat = cur.dat << sh;
`ifdef SHIFTER_STICKY_EN
                        lvl_res[k].stk = cur.stk | (|(cur.dat & ~(ones >> sh)));
`endif
                    end
                    OP_SRL: begin
                        lvl_res[k].dat = cur.dat >> sh;
`ifdef SHIFTER_STICKY_EN
                        lvl_res[k].stk = cur.stk | (|(cur.dat & ~(ones << sh)));
`endif
                    end
                    OP_SRA: begin
                        lvl_res[k].dat = (cur.dat >> sh) | (cur.sgn ? ~(ones >> sh) : '0);
`ifdef SHIFTER_STICKY_EN
                        lvl_res[k].stk = cur.stk | (|(cur.dat & ~(ones << sh)));
`endif
                    end
                    default: begin
                        lvl_res[k].dat = (cur.dat >> sh) | (cur.dat << (WIDTH - sh));
                    end
                endcase
            end
        end
    end

    // Stage registers advance together on en; reset empties the pipe and clears the visible result.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < L; j++)
                stg_q[j] <= '0;
        end else if (en) begin
            for (int j = 0; j < L; j++)
                stg_q[j] <= lvl_res[((j + 1) * REG_EVERY > LOG2W) ? LOG2W - 1 : (j + 1) * REG_EVERY - 1];
        end
    end
endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter (WIDTH=32, REG_EVERY=2, L=3).
// Directed table, backpressure and mid-stream reset sequences, then randomized traffic.
// Expected results come from an arithmetic reference model and an in-order scoreboard.
module tb_pipelined_shifter;
    localparam int WIDTH     = 32;
    localparam int REG_EVERY = 2;
    localparam int TAG_W     = 4;
    localparam int LAT       = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipelined_shifter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) ifc();

    pipelined_shifter #(.WIDTH(WIDTH), .REG_EVERY(REG_EVERY), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  tag;
        logic        stk;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] d;
        logic [31:0] s;
        logic [31:0] y;
        logic        stk;
    } vec_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          n_dlv = 0;
    bit          last_acc;
    bit          last_dlv;
    bit          lat_chk = 1'b0;
    bit          use_tbl = 1'b0;
    logic [31:0] tbl_y;
    logic        tbl_stk;

    // Reference: shift semantics straight from arithmetic on a widened word.
    function automatic logic [31:0] ref_y(input logic [1:0] op, input logic [31:0] d, input logic [31:0] s);
        logic [63:0] w;
        case (op)
            2'b00: begin
                if (s >= 32) return 32'h0;
                w = {32'h0, d} << s;
                return w[31:0];
            end
            2'b01: begin
                if (s >= 32) return 32'h0;
                w = {32'h0, d} >> s;
                return w[31:0];
            end
            2'b10: begin
                if (s >= 32) return {32{d[31]}};
                w = {{32{d[31]}}, d};
                w = w >> s;
                return w[31:0];
            end
            default: begin
                w = {d, d};
                w = w >> s[4:0];
                return w[31:0];
            end
        endcase
    endfunction

    function automatic logic ref_stk(input logic [1:0] op, input logic [31:0] d, input logic [31:0] s);
        logic [63:0] w;
        if (op == 2'b11) return 1'b0;
        if (s >= 32) return |d;
        if (op == 2'b00) begin
            w = {32'h0, d} << s;
            return |w[63:32];
        end
        w = {d, 32'h0} >> s;
        return |w[31:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    endtask

    // One clock: score the output handshake, record an accepted operation, advance past the edge.
    task automatic tick();
        exp_t e;
        #1;
        last_acc = 1'b0;
        last_dlv = 1'b0;
        if (!rst && ifc.out_valid && ifc.out_ready) begin
            last_dlv = 1'b1;
            n_dlv++;
            chk("result_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("y", 64'(ifc.y), 64'(e.y));
                chk("out_tag", 64'(ifc.out_tag), 64'(e.tag));
`ifdef SHIFTER_STICKY_EN
                chk("sticky", 64'(ifc.sticky), 64'(e.stk));
`endif
                if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'(LAT));
            end
        end
        if (!rst && ifc.in_valid && ifc.in_ready) begin
            last_acc = 1'b1;
            e.y   = use_tbl ? tbl_y   : ref_y(ifc.op, ifc.d, ifc.s);
            e.stk = use_tbl ? tbl_stk : ref_stk(ifc.op, ifc.d, ifc.s);
            e.tag = ifc.in_tag;
            e.cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        cyc++;
        if (rst) sb.delete();
        #1;
    endtask

    task automatic drain(input int bound);
        for (int k = 0; k < bound && sb.size() > 0; k++) tick();
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [11];
        int   nt;
        int   dl;
        int   base;

        tbl[0]  = '{2'd0, 32'h00000001, 32'd31,    32'h80000000, 1'b0};
        tbl[1]  = '{2'd0, 32'h00000001, 32'd32,    32'h00000000, 1'b1};
        tbl[2]  = '{2'd2, 32'h80000000, 32'd4,     32'hF8000000, 1'b0};
        tbl[3]  = '{2'd2, 32'h80000000, 32'h100,   32'hFFFFFFFF, 1'b1};
        tbl[4]  = '{2'd2, 32'h40000000, 32'h100,   32'h00000000, 1'b1};
        tbl[5]  = '{2'd3, 32'h12345678, 32'd36,    32'h81234567, 1'b0};
        tbl[6]  = '{2'd3, 32'h12345678, 32'd64,    32'h12345678, 1'b0};
        tbl[7]  = '{2'd1, 32'h000000FF, 32'd4,     32'h0000000F, 1'b1};
        tbl[8]  = '{2'd1, 32'h000000FF, 32'd0,     32'h000000FF, 1'b0};
        tbl[9]  = '{2'd3, 32'hDEADBEEF, 32'd0,     32'hDEADBEEF, 1'b0};
        tbl[10] = '{2'd0, 32'hA5A5A5A5, 32'd8,     32'hA5A5A500, 1'b1};

        ifc.in_valid  = 1'b0;
        ifc.d         = '0;
        ifc.s         = '0;
        ifc.op        = '0;
        ifc.in_tag    = '0;
        ifc.out_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("rst_y",         64'(ifc.y),         64'd0);
        chk("rst_out_tag",   64'(ifc.out_tag),   64'd0);
        chk("rst_in_ready",  64'(ifc.in_ready),  64'd1);
`ifdef SHIFTER_STICKY_EN
        chk("rst_sticky",    64'(ifc.sticky),    64'd0);
`endif
        rst = 1'b0;

        // Directed table: one operation at a time, latency checked
        use_tbl = 1'b1;
        lat_chk = 1'b1;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            ifc.in_valid = 1'b1;
            ifc.op       = tbl[i].op;
            ifc.d        = tbl[i].d;
            ifc.s        = tbl[i].s;
            ifc.in_tag   = 4'(i);
            tbl_y        = tbl[i].y;
            tbl_stk      = tbl[i].stk;
            tick();
            chk("tbl_accept", 64'(last_acc), 64'd1);
            ifc.in_valid = 1'b0;
            drain(20);
        end
        use_tbl = 1'b0;
        lat_chk = 1'b0;

        // Backpressure: tags 1..5 back-to-back, out_ready low for 2 cycles after first result
        base = n_dlv;
        nt = 1;
        dl = -1;
        for (int i = 0; i < 40 && (nt <= 5 || sb.size() > 0); i++) begin
            ifc.in_valid  = (nt <= 5);
            ifc.in_tag    = 4'(nt);
            ifc.op        = 2'($urandom);
            ifc.d         = $urandom;
            ifc.s         = 32'($urandom_range(0, 40));
            ifc.out_ready = (dl > 0) ? 1'b0 : 1'b1;
            #1;
            if (dl > 0) begin
                chk("bp_in_ready_low", 64'(ifc.in_ready),  64'd0);
                chk("bp_out_valid",    64'(ifc.out_valid), 64'd1);
                if (sb.size() > 0) begin
                    chk("bp_y_stable",   64'(ifc.y),       64'(sb[0].y));
                    chk("bp_tag_stable", 64'(ifc.out_tag), 64'(sb[0].tag));
                end
            end else begin
                chk("bp_in_ready_high", 64'(ifc.in_ready), 64'd1);
            end
            tick();
            if (last_acc) nt++;
            if (dl > 0)
                dl--;
            else if (dl < 0 && last_dlv)
                dl = 2;
        end
        chk("bp_delivered", 64'(n_dlv - base), 64'd5);
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        drain(20);

        // Reset with three operations in flight
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ifc.in_valid = 1'b1;
            ifc.op       = 2'($urandom);
            ifc.d        = $urandom;
            ifc.s        = 32'($urandom_range(1, 31));
            ifc.in_tag   = 4'(9 + i);
            tick();
            chk("rs_accept", 64'(last_acc), 64'd1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifc.in_valid = 1'b0;
        chk("rs_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("rs_y",         64'(ifc.y),         64'd0);
        chk("rs_out_tag",   64'(ifc.out_tag),   64'd0);
        chk("rs_in_ready",  64'(ifc.in_ready),  64'd1);
        base = n_dlv;
        ifc.out_ready = 1'b1;
        repeat (8) tick();
        chk("rs_no_output", 64'(n_dlv - base), 64'd0);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            ifc.in_valid  = ($urandom_range(0, 3) != 0);
            ifc.op        = 2'($urandom);
            ifc.d         = $urandom;
            ifc.s         = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
            ifc.in_tag    = 4'($urandom);
            ifc.out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        drain(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
